multi_digit_ud_counter: RTL
===========================

MULTI_DIGIT_UD_COUNTER -- requirements
Module: multi_digit_ud_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of cascaded 4-bit digits (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port enable  input  1  count-step request for this cycle.
REQ-005 SHALL have port updown  input  1  direction, 1 = up, 0 = down.
REQ-006 SHALL have port mode  input  1  digit radix, 1 = BCD (0..9), 0 = hex (0..F).
REQ-007 SHALL have port oneshot  input  1  1 = stop at terminal value, 0 = wrap.
REQ-008 SHALL have port load  input  1  parallel load strobe.
REQ-009 SHALL have port load_count  input  4*DIGITS  parallel load value, digit 0 in bits [3:0].
REQ-010 SHALL have port count_out  output  4*DIGITS  current count, digit 0 in bits [3:0].
REQ-011 SHALL have port done  output  1  count equals terminal value for current mode/updown.
REQ-012 SHALL have port wrap  output  1  wrap-around indication.

Function
REQ-013 SHALL apply priority reset > load > enable each cycle; with none asserted the count holds.
REQ-014 SHALL on load write load_count to count_out next cycle; in BCD mode any loaded digit > 9 SHALL be clamped to 9.
REQ-015 SHALL define digit max as 9 (BCD) or F (hex); terminal value is all digits max (up) or all digits 0 (down).
REQ-016 SHALL on an enabled up step increment digit 0 and increment digit i only when all digits below i are at max; a digit at max rolls to 0.
REQ-017 SHALL on an enabled down step decrement digit 0 and decrement digit i only when all digits below i are 0; a digit at 0 rolls to max.
REQ-018 SHALL in BCD mode treat any stored digit > 9 as 9 when computing an enabled step (mode changed while holding a hex value).
REQ-019 SHALL drive done combinationally as (count_out == terminal value) for current mode and updown, with raw stored digits.
REQ-020 SHALL when enabled at terminal value with oneshot = 0 wrap to all 0 (up) or all max (down) in one cycle.
REQ-021 SHALL when enabled at terminal value with oneshot = 1 hold the count; no wrap occurs.
REQ-022 SHALL assert wrap registered, in the cycle after a wrap of REQ-020 occurred.
REQ-023 SHALL complete a full-width carry/borrow ripple within one cycle (step latency 1 clock for any DIGITS).
REQ-024 SHALL evaluate direction/mode changes on the same edge they are sampled; no pipeline delay.

Reset
REQ-025 SHALL on reset set count_out to 0 and wrap to 0 on the next rising edge, overriding load and enable.
REQ-026 SHALL after reset drive done = 1 if updown = 0, else 0, per REQ-019.
REQ-027 SHALL allow reset asserted mid-count or mid-load with no residual state after one edge.

Configuration
REQ-028 SHALL support macro UDC_WRAP_STICKY_EN.
REQ-029 SHALL with UDC_WRAP_STICKY_EN defined hold wrap at 1 after a wrap until the next load or reset.
REQ-030 SHALL without UDC_WRAP_STICKY_EN drive wrap as a one-cycle pulse per wrap event.

Verification (DIGITS = 2)
REQ-031 SHALL cover BCD up: reset, mode=1, updown=1, enable 100 cycles -> 00,01..09,10..99, then 00 with wrap pulse; done=1 only while 99.
REQ-032 SHALL cover hex down: load 0x10, mode=0, updown=0, enable 2 cycles -> 0F then 0E; done=0 throughout.
REQ-033 SHALL cover oneshot: load 0x98, mode=1, updown=1, oneshot=1, enable 3 cycles -> 99, 99, 99; done=1, wrap never asserted.
REQ-034 SHALL cover load clamp and priority: mode=1, load=1 with enable=1, load_count=0xA7 -> count_out 0x97 next cycle, enable ignored.
REQ-035 SHALL cover reset mid-count: at count 0x45 assert reset with load=1 and enable=1 -> count_out 00, wrap 0 next cycle.
REQ-036 SHALL cover macro: wrap from 99 to 00, then 3 idle cycles -> wrap high for 4 cycles with UDC_WRAP_STICKY_EN, 1 cycle without.

Source files
------------

// File: rtl/multi_digit_ud_counter.sv
// rtl/multi_digit_ud_counter.sv - cascaded BCD/hex up/down counter with load, oneshot and wrap flag (option: UDC_WRAP_STICKY_EN)
module multi_digit_ud_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  updown,
    input  logic                  mode,
    input  logic                  oneshot,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_count,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  done,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] step_count;
    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] terminal;
    logic [3:0]          digit_max;
    logic [3:0]          eff [DIGITS];
    logic                carry_out;
    logic                wrap_event;

    assign digit_max = mode ? 4'd9 : 4'd15;
    assign count_out = count_q;

    // Effective digit values: in BCD mode a leftover hex digit above 9 behaves as 9
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            eff[i] = count_q[4*i +: 4];
            if (mode && (count_q[4*i +: 4] > 4'd9)) begin
                eff[i] = 4'd9;
            end
        end
    end

    // Ripple carry/borrow across all digits in one cycle; carry_out flags a terminal-to-wrap step
    always_comb begin
        logic chain;
        chain      = 1'b1;
        step_count = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (updown) begin
                    step_count[4*i +: 4] = (eff[i] == digit_max) ? 4'd0 : eff[i] + 4'd1;
                end else begin
                    step_count[4*i +: 4] = (eff[i] == 4'd0) ? digit_max : eff[i] - 4'd1;
                end
            end else begin
                step_count[4*i +: 4] = eff[i];
            end
            chain = chain & (updown ? (eff[i] == digit_max) : (eff[i] == 4'd0));
        end
        carry_out = chain;
    end

    // Parallel load value, with BCD digits above 9 clamped to 9
    always_comb begin
        load_clamped = load_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (mode && (load_count[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Terminal value for the current mode and direction; done compares raw stored digits
    always_comb begin
        terminal = '0;
        for (int i = 0; i < DIGITS; i++) begin
            terminal[4*i +: 4] = updown ? digit_max : 4'd0;
        end
    end

    assign done       = (count_q == terminal);
    assign wrap_event = enable && carry_out && !oneshot;

    // Count register: reset > load > enable; oneshot holds at terminal
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_clamped;
        end else if (enable && !(carry_out && oneshot)) begin
            count_q <= step_count;
        end
    end

`ifdef UDC_WRAP_STICKY_EN
    // Sticky wrap flag: set by a wrap, cleared only by load or reset
    always_ff @(posedge clk) begin
        if (reset || load) begin
            wrap <= 1'b0;
        end else if (wrap_event) begin
            wrap <= 1'b1;
        end
    end
`else
    // One-cycle wrap pulse following each wrap step
    always_ff @(posedge clk) begin
        if (reset || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_event;
        end
    end
`endif

endmodule
